sincos_nco: RTL and testbench

SINCOS_NCO -- requirements
Module: sincos_nco

---
 rtl/sincos_pkg.sv | 27 ++
 rtl/sincos_qrom.sv | 35 +++
 rtl/sincos_nco.sv | 144 ++++++++++++++
 tb/tb_sincos_nco.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/sincos_pkg.sv
// Shared definitions for the sine/cosine NCO: quadrant encoding, dither LFSR
// constants and the quarter-wave table generator used at elaboration.
package sincos_pkg;

    typedef enum logic [1:0] {
        QUAD_0 = 2'd0,
        QUAD_1 = 2'd1,
        QUAD_2 = 2'd2,
        QUAD_3 = 2'd3
    } quad_t;

    // Fibonacci x^16+x^14+x^13+x^11+1 in right-shift form: feedback taps bits 0,2,3,5
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    localparam real PI = 3.14159265358979323846;

    // Half-step sampled quarter sine; every entry is non-negative so +0.5 rounds to nearest
    function automatic int qrom_entry(input int k, input int addr_w, input int out_w);
        real amp;
        real ang;
        amp = real'((1 << (out_w - 1)) - 1);
        ang = 2.0 * PI * (real'(k) + 0.5) / real'(1 << addr_w);
        return $rtoi(amp * $sin(ang) + 0.5);
    endfunction

endpackage

// File: rtl/sincos_qrom.sv
// Quarter-wave sine magnitude table with two registered read ports; contents
// are generated from the table parameters at elaboration.
module sincos_qrom
    import sincos_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int OUT_W  = 12
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-3:0] sin_addr,
    input  logic [ADDR_W-3:0] cos_addr,
    output logic [OUT_W-2:0]  sin_data,
    output logic [OUT_W-2:0]  cos_data
);

    localparam int DEPTH = 1 << (ADDR_W - 2);

    logic [OUT_W-2:0] rom [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_rom
        assign rom[k] = (OUT_W-1)'(qrom_entry(k, ADDR_W, OUT_W));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sin_data <= '0;
            cos_data <= '0;
        end else begin
            sin_data <= rom[sin_addr];
            cos_data <= rom[cos_addr];
        end
    end

endmodule

// File: rtl/sincos_nco.sv
// Phase-accumulator NCO producing signed sine and cosine from a mirrored quarter table.
// Optional phase dither is enabled by defining SINCOS_NCO_DITHER_EN.
module sincos_nco
    import sincos_pkg::*;
#(
    parameter int PHASE_W = 24,
    parameter int ADDR_W  = 10,
    parameter int OUT_W   = 12
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     en,
    input  logic                     sync,
    input  logic [PHASE_W-1:0]       freq_word,
    input  logic [PHASE_W-1:0]       phase_off,
    output logic signed [OUT_W-1:0]  sin_out,
    output logic signed [OUT_W-1:0]  cos_out,
    output logic                     out_valid
);

    localparam int A_W = ADDR_W - 2;

    logic [PHASE_W-1:0] acc;
    logic [PHASE_W-1:0] phase;
    logic               launch;
    logic [ADDR_W-1:0]  idx;
    logic [ADDR_W-1:0]  idx_p0;
    logic               vld_p0, vld_p1, vld_p2;
    quad_t              q_p1, q_p2;
    logic [A_W-1:0]     a_p1;
    logic [A_W-1:0]     sin_addr, cos_addr;
    logic [OUT_W-2:0]   sin_mag_p2, cos_mag_p2;
    logic               sin_neg, cos_neg;

    function automatic logic signed [OUT_W-1:0] apply_sign(input logic [OUT_W-2:0] mag,
                                                           input logic neg);
        logic signed [OUT_W-1:0] ext;
        ext = signed'({1'b0, mag});
        return neg ? -ext : ext;
    endfunction

    assign launch = en & ~sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc <= '0;
        end else if (sync) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + freq_word;
        end
    end

`ifdef SINCOS_NCO_DITHER_EN
    localparam int DITH_W = (PHASE_W - ADDR_W < 16) ? (PHASE_W - ADDR_W) : 16;
    localparam logic [15:0] DITH_MASK = 16'((32'd1 << DITH_W) - 32'd1);

    logic [15:0] lfsr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr <= LFSR_SEED;
        end else if (launch) begin
            lfsr <= {^(lfsr & LFSR_TAPS), lfsr[15:1]};
        end
    end

    assign phase = acc + phase_off + PHASE_W'(lfsr & DITH_MASK);
`else
    assign phase = acc + phase_off;
`endif

    assign idx = ADDR_W'(phase >> (PHASE_W - ADDR_W));

    // Stage 0: launch captures the table index
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_p0 <= '0;
            vld_p0 <= 1'b0;
        end else begin
            idx_p0 <= idx;
            vld_p0 <= launch;
        end
    end

    // Stage 1: quadrant and in-quadrant address
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_p1   <= QUAD_0;
            a_p1   <= '0;
            vld_p1 <= 1'b0;
        end else begin
            q_p1   <= quad_t'(idx_p0[ADDR_W-1 -: 2]);
            a_p1   <= idx_p0[A_W-1:0];
            vld_p1 <= vld_p0;
        end
    end

    // Odd quadrants read the table mirrored for sine; cosine is the opposite
    assign sin_addr = (q_p1 == QUAD_1 || q_p1 == QUAD_3) ? ~a_p1 : a_p1;
    assign cos_addr = (q_p1 == QUAD_1 || q_p1 == QUAD_3) ? a_p1 : ~a_p1;

    // Stage 2: table read
    sincos_qrom #(
        .ADDR_W (ADDR_W),
        .OUT_W  (OUT_W)
    ) u_qrom (
        .clk      (clk),
        .reset_n  (reset_n),
        .sin_addr (sin_addr),
        .cos_addr (cos_addr),
        .sin_data (sin_mag_p2),
        .cos_data (cos_mag_p2)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_p2   <= QUAD_0;
            vld_p2 <= 1'b0;
        end else begin
            q_p2   <= q_p1;
            vld_p2 <= vld_p1;
        end
    end

    assign sin_neg = (q_p2 == QUAD_2) || (q_p2 == QUAD_3);
    assign cos_neg = (q_p2 == QUAD_1) || (q_p2 == QUAD_2);

    // Stage 3: sign apply; outputs hold between samples
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sin_out   <= '0;
            cos_out   <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= vld_p2;
            if (vld_p2) begin
                sin_out <= apply_sign(sin_mag_p2, sin_neg);
                cos_out <= apply_sign(cos_mag_p2, cos_neg);
            end
        end
    end

endmodule

// File: tb/tb_sincos_nco.sv
// Randomised bench for sincos_nco against an ideal-trigonometry reference model.
module tb_sincos_nco;

    localparam int     PHASE_W = 24;
    localparam int     ADDR_W  = 10;
    localparam int     OUT_W   = 12;
    localparam longint MASK    = (longint'(1) << PHASE_W) - 1;
    localparam real    PI      = 3.14159265358979323846;

    logic                     clk = 1'b0;
    logic                     reset_n = 1'b0;
    logic                     en = 1'b0;
    logic                     sync = 1'b0;
    logic [PHASE_W-1:0]       freq_word = '0;
    logic [PHASE_W-1:0]       phase_off = '0;
    logic signed [OUT_W-1:0]  sin_out;
    logic signed [OUT_W-1:0]  cos_out;
    logic                     out_valid;

    int     checks = 0;
    int     errors = 0;
    longint macc;
    bit     lv [3];
    int     ls [3];
    int     lc [3];
    int     exp_sin, exp_cos;
    bit     exp_valid;

    always #5 clk = ~clk;

    sincos_nco #(
        .PHASE_W (PHASE_W),
        .ADDR_W  (ADDR_W),
        .OUT_W   (OUT_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (en),
        .sync      (sync),
        .freq_word (freq_word),
        .phase_off (phase_off),
        .sin_out   (sin_out),
        .cos_out   (cos_out),
        .out_valid (out_valid)
    );

    task automatic check_val(input string tag, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, want, $time);
        end
    endtask

    function automatic int round_away(input real x);
        if (x >= 0.0) return $rtoi($floor(x + 0.5));
        return -$rtoi($floor(-x + 0.5));
    endfunction

    // Ideal sample at the centre of table step idx
    task automatic ideal(input int idx, output int s, output int c);
        real amp, theta;
        amp   = real'((1 << (OUT_W - 1)) - 1);
        theta = 2.0 * PI * (real'(idx) + 0.5) / real'(1 << ADDR_W);
        s = round_away(amp * $sin(theta));
        c = round_away(amp * $cos(theta));
    endtask

    task automatic model_reset();
        macc = 0;
        for (int i = 0; i < 3; i++) begin
            lv[i] = 1'b0;
            ls[i] = 0;
            lc[i] = 0;
        end
        exp_sin   = 0;
        exp_cos   = 0;
        exp_valid = 1'b0;
    endtask

    task automatic cycle(input bit e, input bit sy, input logic [PHASE_W-1:0] fw,
                         input logic [PHASE_W-1:0] po);
        bit     launch, popped;
        int     ns, nc, ps, pc;
        longint p;
        en        = e;
        sync      = sy;
        freq_word = fw;
        phase_off = po;
        @(posedge clk);
        launch = e && !sy;
        ns = 0;
        nc = 0;
        if (launch) begin
            p = (macc + longint'(po)) & MASK;
            ideal(int'(p >> (PHASE_W - ADDR_W)), ns, nc);
        end
        if (sy) macc = 0;
        else if (e) macc = (macc + longint'(fw)) & MASK;
        popped = lv[2];
        ps = ls[2];
        pc = lc[2];
        for (int i = 2; i > 0; i--) begin
            lv[i] = lv[i-1];
            ls[i] = ls[i-1];
            lc[i] = lc[i-1];
        end
        lv[0] = launch;
        ls[0] = ns;
        lc[0] = nc;
        exp_valid = popped;
        if (popped) begin
            exp_sin = ps;
            exp_cos = pc;
        end
        #1;
        check_val("out_valid", int'(out_valid), int'(exp_valid));
        check_val("sin_out", int'(sin_out), exp_sin);
        check_val("cos_out", int'(cos_out), exp_cos);
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_valid", int'(out_valid), 0);
        check_val("rst_sin", int'(sin_out), 0);
        check_val("rst_cos", int'(cos_out), 0);
        reset_n = 1'b1;

        // Continuous sweep one index per sample, long enough to wrap the accumulator
        for (int i = 0; i < 1100; i++) begin
            cycle(1'b1, 1'b0, 24'h004000, 24'h000000);
            if (i == 3) begin
                check_val("first_sin", int'(sin_out), 6);
                check_val("first_cos", int'(cos_out), 2047);
            end
            if (i == 4) begin
                check_val("second_sin", int'(sin_out), 19);
                check_val("second_cos", int'(cos_out), 2047);
            end
        end

        for (int i = 0; i < 12; i++)
            cycle(i % 2 == 0, 1'b0, 24'($urandom), 24'($urandom));

        repeat (3) cycle(1'b1, 1'b0, 24'h004000, 24'h000000);
        cycle(1'b1, 1'b1, 24'h004000, 24'h000000);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b0, 24'h004000, 24'h000000);
            if (i == 3) begin
                check_val("sync_sin", int'(sin_out), 6);
                check_val("sync_cos", int'(cos_out), 2047);
            end
        end

        cycle(1'b0, 1'b1, 24'h000000, 24'h000000);
        repeat (6) cycle(1'b1, 1'b0, 24'h000000, 24'h400000);
        check_val("off90_sin", int'(sin_out), 2047);
        check_val("off90_cos", int'(cos_out), -6);
        repeat (6) cycle(1'b1, 1'b0, 24'h000000, 24'h800000);
        check_val("off180_sin", int'(sin_out), -6);
        check_val("off180_cos", int'(cos_out), -2047);

        repeat (400)
            cycle($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
                  24'($urandom), 24'($urandom));

        repeat (5) cycle(1'b1, 1'b0, 24'($urandom), 24'($urandom));
        #2 reset_n = 1'b0;
        #1;
        check_val("midrst_valid", int'(out_valid), 0);
        check_val("midrst_sin", int'(sin_out), 0);
        check_val("midrst_cos", int'(cos_out), 0);
        model_reset();
        #1 reset_n = 1'b1;
        repeat (30)
            cycle($urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0,
                  24'($urandom), 24'($urandom));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
